// File: rtl/mips_tb_pkg.sv
// -----------------------------------------------------------------------------
// mips_tb_pkg
// Shared definitions for the MIPS directed-test infrastructure.
//   run_state_t  : run-checker FSM states
//   HALT_ADDR    : fetch address the CPU jumps to when the program ends
//   RESET_VECTOR : first fetch address after CPU reset
// -----------------------------------------------------------------------------
package mips_tb_pkg;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        RUN        = 2'd1,
        DONE       = 2'd2,
        TIMEOUT    = 2'd3
    } run_state_t;

    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/mips_run_checker.sv
// -----------------------------------------------------------------------------
// mips_run_checker
// Watches the observable outputs of mips_cpu_harvard. It detects program halt
// (active falling), latches the final $v0, the cycle count and the last
// non-zero fetch address, and reports pass / fail / timeout as sticky flags.
//
// Parameters
//   TIMEOUT_CYCLES : RUN cycles allowed before timeout (>= 2)
//   CNT_W          : cycle counter width (2**CNT_W > TIMEOUT_CYCLES)
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   clk_enable     : same enable as the CPU; 0 freezes all checker state
//   active         : CPU active flag
//   instr_address  : CPU fetch address
//   register_v0    : CPU $v0
//   check_en       : 1 = compare $v0 against expected_v0, 0 = any halt passes
//   expected_v0    : golden $v0
//   done, pass, fail, timeout : sticky result flags
//   v0_captured    : $v0 sampled on the halt edge
//   halt_pc        : last non-zero fetch address seen during RUN
//   cycles         : number of enabled RUN cycles
// -----------------------------------------------------------------------------
module mips_run_checker
    import mips_tb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_enable,
    input  logic             active,
    input  logic [31:0]      instr_address,
    input  logic [31:0]      register_v0,
    input  logic             check_en,
    input  logic [31:0]      expected_v0,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [31:0]      v0_captured,
    output logic [31:0]      halt_pc,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] CYCLE_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    run_state_t state;
    logic       v0_mismatch;

    assign v0_mismatch = check_en && (register_v0 != expected_v0);

    // done/timeout are pure decodes of the state register, so they stay
    // registered outputs and can never both be set.
    assign done    = (state == DONE);
    assign timeout = (state == TIMEOUT);

    // Main FSM. The halt test is ordered before the budget test so a halt on
    // the final budget cycle still counts as a normal finish. The counter
    // only advances on RUN cycles that neither halt nor time out, which is
    // why it holds its previous value on the halt edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_START;
            pass        <= 1'b0;
            fail        <= 1'b0;
            v0_captured <= '0;
            halt_pc     <= '0;
            cycles      <= '0;
        end else if (clk_enable) begin
            case (state)
                WAIT_START: begin
                    if (active) begin
                        state  <= RUN;
                        cycles <= CNT_W'(1);
                    end
                end
                RUN: begin
                    // Fetches of address 0 are either the halt jump or a
                    // transient; neither is a meaningful program counter.
                    if (instr_address != HALT_ADDR) begin
                        halt_pc <= instr_address;
                    end
                    if (!active) begin
                        state       <= DONE;
                        v0_captured <= register_v0;
                        fail        <= v0_mismatch;
                        pass        <= !v0_mismatch;
                    end else if (cycles == CYCLE_LIMIT) begin
                        state <= TIMEOUT;
                    end else begin
                        cycles <= cycles + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE and TIMEOUT are terminal until reset.
                end
            endcase
        end
    end

endmodule

// File: doc/mips_run_checker.md
# mips_run_checker

Self-checking run monitor that sits directly downstream of `mips_cpu_harvard` in every directed test bench. It consumes the CPU's observable outputs (`active`, `instr_address`, `register_v0`), detects program halt (CPU deasserts `active` after jumping to address 0), and latches the final `register_v0`, the cycle count and the last non-zero fetch address. It then reports pass, fail or timeout as sticky registered flags. This replaces per-bench ad hoc `instr_address==0` assertions with one reusable, cycle-accurate checker.

## Interface
- `TIMEOUT_CYCLES`, default 1000: maximum RUN cycles before declaring timeout; must be ≥ 2.
- `CNT_W`, default 16: width of the cycle counter; 2^CNT_W must exceed `TIMEOUT_CYCLES`.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_enable` in 1: same signal driven to the CPU; when 0, the checker holds all state.
- `active` in 1: CPU active flag.
- `instr_address` in 32: CPU fetch address.
- `register_v0` in 32: CPU `$v0` value.
- `check_en` in 1: 1 = compare against `expected_v0`; 0 = any halt is a pass.
- `expected_v0` in 32: golden `$v0` value; must be stable from reset release to done.
- `done` out 1: halt detected; sticky.
- `pass` out 1: done and the result is acceptable; sticky.
- `fail` out 1: done and `$v0` mismatches; sticky.
- `timeout` out 1: cycle budget exhausted without halt; sticky.
- `v0_captured` out 32: `register_v0` sampled on the halt edge.
- `halt_pc` out 32: last `instr_address` ≠ 0 seen during RUN.
- `cycles` out CNT_W: count of enabled RUN cycles.

## Operation
- FSM states: WAIT_START, RUN, DONE, TIMEOUT. The reset state is WAIT_START.
- All transitions require `clk_enable` = 1. With `clk_enable` = 0, state, counter and captures hold.
- **WAIT_START**
  - `active` = 1 → RUN. `cycles` is set to 1 on that edge.
  - `active` = 0 → stay.
- **RUN**, on each enabled edge:
  - If `instr_address` ≠ 0, set `halt_pc` ← `instr_address`.
  - If `active` = 0 → DONE. On the same edge set `v0_captured` ← `register_v0`, and latch `fail` ← `check_en` && (`register_v0` ≠ `expected_v0`). `pass` is the complement of that `fail` value.
  - Else if `cycles` = `TIMEOUT_CYCLES` → TIMEOUT.
  - Else `cycles` ← `cycles` + 1. Use unsigned arithmetic; the counter never wraps because the timeout fires first.
- **Simultaneous halt and budget exhaustion:** halt wins (DONE, not TIMEOUT).
- **DONE and TIMEOUT:** terminal until `reset_n` is asserted. Later `active` or `instr_address` changes have no effect.
- **Flag exclusivity:** `done` = (state == DONE); `timeout` = (state == TIMEOUT); at most one of `pass` / `fail` is ever 1.

## Timing
- **Reset values:** all outputs are 0. `halt_pc` = 0, `v0_captured` = 0, `cycles` = 0.
- **Reset behaviour:** asserting `reset_n` low clears every output immediately, with no clock needed. This includes mid-RUN and after DONE.
- **Output registration:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Halt latency:** `active` sampled 0 at edge N → `done` / `pass` / `fail` / `v0_captured` valid after edge N. `cycles` holds its edge N−1 value.
- **Timeout latency:** `timeout` rises on the edge after the one where `cycles` reached `TIMEOUT_CYCLES`.
- **Halt fetch handling:** `halt_pc` never records the halt fetch to address 0. An `instr_address` of 0 while `active` = 1 (a transient fetch) is not treated as halt.

## Structure
- Package `mips_tb_pkg` holds:
  - the state enum `run_state_t` {WAIT_START, RUN, DONE, TIMEOUT};
  - the constant `HALT_ADDR` = 32'h0000_0000;
  - the constant `RESET_VECTOR` = 32'hBFC0_0000, shared by benches.
- Single flat module; no sub-module. The counter and FSM together are under 150 lines.
- Benches instantiate it alongside `mips_cpu_harvard` and `mips_cpu_data_memory`, then `$fatal` on `fail` or `timeout`.

## Test plan
- **Normal pass:** `active` high for 7 enabled cycles fetching 32'hBFC00000…32'hBFC00018, `register_v0` = 32'h1, `expected_v0` = 32'h1, `check_en` = 1, then `active` = 0 → `done` = 1, `pass` = 1, `fail` = 0, `v0_captured` = 32'h1, `halt_pc` = 32'hBFC00018, `cycles` = 7.
- **Mismatch:** same sequence with `expected_v0` = 32'h0 → `fail` = 1, `pass` = 0. With `check_en` = 0 → `pass` = 1.
- **Timeout:** `TIMEOUT_CYCLES` = 10, `active` held 1 → `timeout` = 1 after the 11th enabled edge, `cycles` = 10, `done` = 0.
- **Halt on the budget edge:** `active` falls on the same edge that `cycles` = 10 → DONE, `timeout` = 0.
- **Clock-enable stall:** `clk_enable` = 0 for 5 cycles mid-RUN → `cycles` frozen; `active` = 0 during the stall is not detected until `clk_enable` = 1.
- **Reset mid-run and after done:** assert `reset_n` = 0 between edges → all outputs read 0 before the next edge. After release, a new run proceeds from WAIT_START.
